// File: rtl/sensor_conditioner.sv
// sensor_conditioner: four identical loop-detector channels, each synchronized,
// debounced and tracked by a presence/stuck-on state machine feeding the light controller.
module sensor_conditioner #(
    parameter logic [15:0] DEB_CYCLES   = 16'd3,
    parameter logic [15:0] HOLD_CYCLES  = 16'd20,
    parameter logic [15:0] STUCK_CYCLES = 16'd1200
) (
    input  logic       clk,
    input  logic       arstN,
    input  logic [3:0] raw_sensor,
    output logic [3:0] sensor,
    output logic [3:0] fault,
    output logic       any_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // A zero debounce length is treated as a single-cycle filter.
    localparam logic [15:0] DEB_EFF    = (DEB_CYCLES == 16'd0) ? 16'd1 : DEB_CYCLES;
    localparam logic [15:0] STUCK_LAST = STUCK_CYCLES - 16'd1;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic [1:0]  sync_q, sync_d;
        logic        f_q, f_d;
        logic [15:0] dc_q, dc_d;
        logic [15:0] hc_q, hc_d;
        logic [15:0] sc_q, sc_d;
        state_t      state_q, state_d;

        always_ff @(posedge clk or negedge arstN) begin
            if (!arstN) begin
                sync_q  <= 2'b00;
                f_q     <= 1'b0;
                dc_q    <= 16'd0;
                hc_q    <= 16'd0;
                sc_q    <= 16'd0;
                state_q <= IDLE;
            end else begin
                sync_q  <= sync_d;
                f_q     <= f_d;
                dc_q    <= dc_d;
                hc_q    <= hc_d;
                sc_q    <= sc_d;
                state_q <= state_d;
            end
        end

        always_comb begin
            sync_d = {sync_q[0], raw_sensor[i]};
            f_d    = f_q;
            dc_d   = 16'd0;
            if (sync_q[1] != f_q) begin
                if (dc_q + 16'd1 == DEB_EFF) begin
                    f_d = ~f_q;
                end else begin
                    dc_d = dc_q + 16'd1;
                end
            end
        end

        // The stuck window counts only an uninterrupted ACTIVE stay; HOLD->ACTIVE restarts it.
        always_comb begin
            state_d = state_q;
            hc_d    = hc_q;
            sc_d    = sc_q;
            case (state_q)
                IDLE: begin
                    if (f_q) begin
                        state_d = ACTIVE;
                        sc_d    = 16'd0;
                    end
                end
                ACTIVE: begin
                    sc_d = (sc_q == 16'hFFFF) ? sc_q : sc_q + 16'd1;
                    if ((STUCK_CYCLES != 16'd0) && (sc_q == STUCK_LAST) && f_q) begin
                        state_d = FAULT;
                    end else if (!f_q) begin
                        if (HOLD_CYCLES == 16'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = HOLD;
                            hc_d    = HOLD_CYCLES;
                        end
                    end
                end
                HOLD: begin
                    if (f_q) begin
                        state_d = ACTIVE;
                        sc_d    = 16'd0;
                    end else begin
                        hc_d = hc_q - 16'd1;
                        if (hc_q == 16'd1) begin
                            state_d = IDLE;
                        end
                    end
                end
                FAULT: begin
                    if (!f_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign sensor[i] = (state_q == ACTIVE) || (state_q == HOLD);
        assign fault[i]  = (state_q == FAULT);
    end

    assign any_fault = |fault;

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Per-road vehicle-sensor front end that turns four raw, asynchronous, noisy loop-detector inputs into the clean `sensor[3:0]` vector consumed by the traffic-light controller. Each road is handled by the same channel logic:

- synchronizer, then debounce filter, then a small state machine;
- a minimum presence hold that bridges gaps between vehicles;
- stuck-on detection that forces a faulty detector's output low, so a jammed sensor cannot hold a green indefinitely.

It sits directly upstream of the controller and runs on the same clock and reset.

## Interface
- `DEB_CYCLES`, default 3, 16-bit: consecutive cycles the synchronized input must differ from the filtered level before the filtered level flips. A value of 0 behaves as 1.
- `HOLD_CYCLES`, default 20, 16-bit: cycles `sensor[i]` stays high after the filtered input falls. 0 means no hold.
- `STUCK_CYCLES`, default 1200, 16-bit: continuous ACTIVE cycles after which the channel is declared faulty. 0 disables stuck detection.
- `clk`  input  1  clock
- `arstN`  input  1  reset, asynchronous, active-low
- `raw_sensor`  input  4  raw detector levels, asynchronous to `clk`, bit i is road i
- `sensor`  output  4  conditioned presence, bit i is road i
- `fault`  output  4  per-road stuck-on fault flag
- `any_fault`  output  1  OR of `fault[3:0]`

## Operation
Each channel i is independent and identical.

- **Synchronizer:** two flops, reset 0. Their output is `s`.
- **Debounce:**
  - Filtered level `f` (reset 0) and a 16-bit counter `dc` (reset 0).
  - If `s == f`: `dc` goes to 0.
  - Otherwise `dc` increments. On the cycle `dc` would reach `DEB_CYCLES`, `f` toggles and `dc` goes to 0.
  - A pulse or glitch on `s` shorter than `DEB_CYCLES` cycles never changes `f`.
- **State machine:** states IDLE, ACTIVE, HOLD, FAULT; reset state IDLE. Counters: `hc` (hold) and `sc` (stuck), both 16-bit, reset 0.
  - IDLE: if `f` = 1, go to ACTIVE with `sc` = 0.
  - ACTIVE:
    - `sc` increments each cycle, saturating.
    - If `STUCK_CYCLES` != 0 and `sc == STUCK_CYCLES-1` while `f` = 1, go to FAULT.
    - Otherwise, if `f` = 0: go to HOLD with `hc` = `HOLD_CYCLES`, or to IDLE if `HOLD_CYCLES` = 0.
  - HOLD:
    - If `f` = 1, go to ACTIVE with `sc` = 0. A new vehicle restarts the stuck window.
    - Otherwise `hc` decrements. When `hc == 1`, go to IDLE.
  - FAULT: if `f` = 0, go to IDLE. There is no hold on fault recovery.
- **Outputs** (combinational from state):
  - `sensor[i]` = 1 in ACTIVE or HOLD.
  - `fault[i]` = 1 in FAULT.
  - `any_fault` = `|fault`.
- **Reset:** asserting `arstN` low at any time immediately forces all flops to 0, all channels to IDLE, and `sensor`, `fault` and `any_fault` to 0. This applies mid-hold and mid-fault as well.
- **Simultaneous events:** channels never interact. All four may change state on the same edge.

## Timing
- Raw rise to `sensor` rise: `DEB_CYCLES`+3 rising edges, counted from the edge that first samples the new raw level.
  - 2 synchronizer edges, then `DEB_CYCLES` debounce edges, then 1 state edge.
- Raw fall to `sensor` fall: `DEB_CYCLES`+3+`HOLD_CYCLES` edges.
- Stuck detection: `sensor[i]` is high for exactly `STUCK_CYCLES` cycles in one uninterrupted ACTIVE stay. On the next edge `sensor[i]` = 0 and `fault[i]` = 1 together.
- Fault clear: `fault[i]` falls `DEB_CYCLES`+3 edges after raw falls. `sensor[i]` stays 0 throughout the clear.
- Hold retrigger: a raw rise during HOLD reaches ACTIVE `DEB_CYCLES`+3 edges after sampling, with no low cycle on `sensor[i]` in between.
- All outputs change only on rising `clk`, except during asynchronous reset.

## Test plan
Bench parameters: `DEB_CYCLES`=3, `HOLD_CYCLES`=8, `STUCK_CYCLES`=50.

1. **Glitch rejection:** `raw_sensor[0]` high for 2 cycles, then low -> `sensor` stays 4'b0000 throughout; `fault` stays 0.
2. **Clean vehicle:** `raw_sensor[1]` high for 20 cycles -> `sensor[1]` rises 6 edges after the first sampled high, and falls 14 edges after the first sampled low.
3. **Hold bridging:** `raw_sensor[2]` high 10 cycles, low 5, high 10 -> `sensor[2]` is one continuous high pulse with no gap.
4. **Stuck-on:**
   - `raw_sensor[3]` held high for 100 cycles -> `sensor[3]` is high for exactly 50 cycles, then `sensor[3]`=0 and `fault[3]`=`any_fault`=1.
   - Raw then low -> `fault[3]` clears after 6 edges, with no `sensor[3]` pulse.
5. **Concurrency:** `raw_sensor`=4'b1111 on one edge, later 4'b0000 -> all four `sensor` bits rise together, and all fall together 14 edges after the drop.
6. **Reset mid-operation:** assert `arstN`=0 with channel 0 in HOLD and channel 3 in FAULT -> `sensor`, `fault` and `any_fault` go to 0 immediately. After release with raw = 0, the outputs stay 0.
